// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
//   RF_ADDR_W / RF_DATA_W : write-port address and data widths
//   RF_NUM_REGS           : number of architectural register addresses
//   PC_REG                : address of r15 (the PC); it is not held in the file
//   rf_wr_t               : one queued write {addr, data}
package rf_pkg;

    localparam int unsigned RF_ADDR_W   = 4;
    localparam int unsigned RF_DATA_W   = 32;
    localparam int unsigned RF_NUM_REGS = 1 << RF_ADDR_W;

    localparam logic [RF_ADDR_W-1:0] PC_REG = 4'hF;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_t;

    function automatic logic is_pc_addr(input logic [RF_ADDR_W-1:0] addr);
        return addr == PC_REG;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the requester channels and the register-file write port.
//   req_valid/req_ready/req_addr/req_data : N_REQ valid/ready writeback channels
//   we3/wa3/wd3                           : registered register-file write port
//   pc_wr_drop                            : pulse when an r15 write was discarded
//   idle                                  : no queued or in-flight write
//   pending_mask                          : present only with RFW_PENDING_MASK_EN
// Modports: master = requesters / register-file side, slave = the arbiter.
interface rf_write_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    import rf_pkg::*;

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [RF_ADDR_W*N_REQ-1:0] req_addr;
    logic [RF_DATA_W*N_REQ-1:0] req_data;
    logic                       we3;
    logic [RF_ADDR_W-1:0]       wa3;
    logic [RF_DATA_W-1:0]       wd3;
    logic                       pc_wr_drop;
    logic                       idle;
`ifdef RFW_PENDING_MASK_EN
    logic [RF_NUM_REGS-1:0]     pending_mask;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we3, wa3, wd3, pc_wr_drop, idle, pending_mask
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we3, wa3, wd3, pc_wr_drop, idle, pending_mask
    );
`else
    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we3, wa3, wd3, pc_wr_drop, idle
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we3, wa3, wd3, pc_wr_drop, idle
    );
`endif

endinterface

// File: rtl/rfw_fifo.sv
// Small FIFO of rf_wr_t entries, one per writeback requester.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : enqueue data_i (ignored while full)
//   pop_i        : dequeue head (ignored while empty)
//   full_o       : no free slot
//   empty_o      : no valid entry
//   head_o       : oldest entry
//   addr_hit_o   : one bit per register targeted by a valid entry (RFW_PENDING_MASK_EN only)
// Depth must be a power of two >= 2; pointers carry one extra wrap bit.
module rfw_fifo
    import rf_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  rf_wr_t                 data_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output rf_wr_t                 head_o
`ifdef RFW_PENDING_MASK_EN
    ,
    output logic [RF_NUM_REGS-1:0] addr_hit_o
`endif
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW:0] rd_ptr_q, rd_ptr_d;
    rf_wr_t        mem_q [Depth];
    logic          do_push;
    logic          do_pop;

    // Same slot index with differing wrap bits means the writer lapped the reader.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned e = 0; e < Depth; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
        end
    end

`ifdef RFW_PENDING_MASK_EN
    logic [PtrW:0]   count;
    logic [PtrW-1:0] slot_ofs;

    assign count = wr_ptr_q - rd_ptr_q;

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        addr_hit_o = '0;
        slot_ofs   = '0;
        for (int unsigned e = 0; e < Depth; e++) begin
            slot_ofs = PtrW'(e) - rd_ptr_q[PtrW-1:0];
            if ({1'b0, slot_ofs} < count) addr_hit_o[mem_q[e].addr] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between N_REQ writeback requesters.
//   clk : clock, all state updates on posedge
//   rst : asynchronous active-high reset
//   bus : rf_write_arbiter_if.slave (requester channels, we3/wa3/wd3, pc_wr_drop, idle)
// Each requester feeds its own rfw_fifo; a round-robin scheduler drains one entry per
// cycle into registered write-port outputs, launched on posedge so the register file
// can sample them on negedge. Writes to r15 are consumed, not queued, and flagged.
// Optional: define RFW_PENDING_MASK_EN to add bus.pending_mask (registers targeted by
// any queued entry or by the write currently on the port).
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic               clk,
    input logic               rst,
    rf_write_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(N_REQ);

    logic [N_REQ-1:0] full;
    logic [N_REQ-1:0] empty;
    logic [N_REQ-1:0] accept;
    logic [N_REQ-1:0] is_pc;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    rf_wr_t           req_ent [N_REQ];
    rf_wr_t           head    [N_REQ];

    logic             gnt_valid;
    logic [IdxW-1:0]  gnt_idx;
    int unsigned      cand;

    logic                 we3_q, we3_d;
    logic [RF_ADDR_W-1:0] wa3_q, wa3_d;
    logic [RF_DATA_W-1:0] wd3_q, wd3_d;
    logic                 drop_q, drop_d;
    logic [IdxW-1:0]      last_grant_q, last_grant_d;

`ifdef RFW_PENDING_MASK_EN
    logic [RF_NUM_REGS-1:0] fifo_hit [N_REQ];
    logic [RF_NUM_REGS-1:0] pend;
`endif

    for (genvar g = 0; g < N_REQ; g++) begin : gen_req
        assign req_ent[g].addr = bus.req_addr[RF_ADDR_W*g +: RF_ADDR_W];
        assign req_ent[g].data = bus.req_data[RF_DATA_W*g +: RF_DATA_W];
        assign is_pc[g]        = is_pc_addr(req_ent[g].addr);
        // Readiness is purely state-based, so a full FIFO refuses even while popping.
        assign accept[g]       = bus.req_valid[g] & ~full[g];
        assign push[g]         = accept[g] & ~is_pc[g];

        rfw_fifo #(
            .Depth (FIFO_DEPTH)
        ) u_fifo (
            .clk_i      (clk),
            .rst_i      (rst),
            .push_i     (push[g]),
            .data_i     (req_ent[g]),
            .pop_i      (pop[g]),
            .full_o     (full[g]),
            .empty_o    (empty[g]),
            .head_o     (head[g])
`ifdef RFW_PENDING_MASK_EN
            ,
            .addr_hit_o (fifo_hit[g])
`endif
        );
    end

    assign bus.req_ready = ~full;

    // Scan from farthest to nearest so the first non-empty FIFO after last_grant wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last_grant_q;
        cand      = 0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            cand = (32'(last_grant_q) + k) % N_REQ;
            if (!empty[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IdxW'(cand);
            end
        end
        pop = '0;
        if (gnt_valid) pop[gnt_idx] = 1'b1;
    end

    always_comb begin
        we3_d        = gnt_valid;
        wa3_d        = wa3_q;
        wd3_d        = wd3_q;
        last_grant_d = last_grant_q;
        if (gnt_valid) begin
            wa3_d        = head[gnt_idx].addr;
            wd3_d        = head[gnt_idx].data;
            last_grant_d = gnt_idx;
        end
        // Simultaneous r15 drops collapse into a single pulse.
        drop_d = |(accept & is_pc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3_q        <= 1'b0;
            wa3_q        <= '0;
            wd3_q        <= '0;
            drop_q       <= 1'b0;
            last_grant_q <= IdxW'(N_REQ - 1);
        end else begin
            we3_q        <= we3_d;
            wa3_q        <= wa3_d;
            wd3_q        <= wd3_d;
            drop_q       <= drop_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.we3        = we3_q;
    assign bus.wa3        = wa3_q;
    assign bus.wd3        = wd3_q;
    assign bus.pc_wr_drop = drop_q;
    assign bus.idle       = (&empty) & ~we3_q;

`ifdef RFW_PENDING_MASK_EN
    always_comb begin
        pend = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pend = pend | fifo_hit[i];
        end
        if (we3_q) pend[wa3_q] = 1'b1;
        pend[PC_REG] = 1'b0;
    end

    assign bus.pending_mask = pend;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter (N_REQ=2, FIFO_DEPTH=2): a table of
// hand-derived vectors, hand sequences for backpressure and mid-operation reset,
// and randomized traffic checked against a queue-based model of the arbiter.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    localparam int unsigned NReq  = 2;
    localparam int unsigned Depth = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.N_REQ(NReq)) bus ();

    rf_write_arbiter #(
        .N_REQ      (NReq),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: per-requester list of pending {addr,data}, plus expected port state.
    logic [35:0] mq [NReq][Depth];
    int          mcnt [NReq];
    int          m_last;
    logic        m_we3;
    logic [3:0]  m_wa3;
    logic [31:0] m_wd3;
    logic        m_drop;

    logic [31:0] cap [$];

    typedef struct {
        bit          rst_first;
        logic [1:0]  v;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        we3;
        logic [3:0]  wa3;
        logic [31:0] wd3;
        logic        drop;
        logic        idle;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NReq; i++) mcnt[i] = 0;
        m_last = NReq - 1;
        m_we3  = 1'b0;
        m_wa3  = 4'h0;
        m_wd3  = 32'h0;
        m_drop = 1'b0;
    endtask

    function automatic logic model_idle();
        logic e;
        e = 1'b1;
        for (int i = 0; i < NReq; i++) if (mcnt[i] != 0) e = 1'b0;
        return e && !m_we3;
    endfunction

    // One clock: drive inputs, predict, advance to just after posedge, compare.
    task automatic step(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        logic [1:0]  rdy;
        logic [3:0]  a [NReq];
        logic [31:0] d [NReq];
        logic [35:0] ent;
        int          g;
        int          j;
        logic [15:0] mask;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        bus.req_valid = v;
        bus.req_addr  = {a1, a0};
        bus.req_data  = {d1, d0};
        for (int i = 0; i < NReq; i++) rdy[i] = (mcnt[i] < Depth);
        chk("req_ready", 32'(bus.req_ready), 32'(rdy));

        g = -1;
        for (int k = NReq; k >= 1; k--) begin
            j = (m_last + k) % NReq;
            if (mcnt[j] > 0) g = j;
        end
        if (g >= 0) begin
            ent = mq[g][0];
            for (int e = 0; e < Depth - 1; e++) mq[g][e] = mq[g][e+1];
            mcnt[g]--;
            m_we3  = 1'b1;
            m_wa3  = ent[35:32];
            m_wd3  = ent[31:0];
            m_last = g;
        end else begin
            m_we3 = 1'b0;
        end
        m_drop = 1'b0;
        for (int i = 0; i < NReq; i++) begin
            if (v[i] && rdy[i]) begin
                if (a[i] == PC_REG) begin
                    m_drop = 1'b1;
                end else begin
                    mq[i][mcnt[i]] = {a[i], d[i]};
                    mcnt[i]++;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("we3", 32'(bus.we3), 32'(m_we3));
        chk("wa3", 32'(bus.wa3), 32'(m_wa3));
        chk("wd3", bus.wd3, m_wd3);
        chk("pc_wr_drop", 32'(bus.pc_wr_drop), 32'(m_drop));
        chk("idle", 32'(bus.idle), 32'(model_idle()));
`ifdef RFW_PENDING_MASK_EN
        mask = '0;
        for (int i = 0; i < NReq; i++)
            for (int e = 0; e < mcnt[i]; e++) mask[mq[i][e][35:32]] = 1'b1;
        if (m_we3) mask[m_wa3] = 1'b1;
        mask[15] = 1'b0;
        chk("pending_mask", 32'(bus.pending_mask), 32'(mask));
`else
        mask = '0;
`endif
        if (bus.we3 && bus.wa3 == 4'd6) cap.push_back(bus.wd3);
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_we3", 32'(bus.we3), 32'd0);
        chk("rst_wa3", 32'(bus.wa3), 32'd0);
        chk("rst_wd3", bus.wd3, 32'd0);
        chk("rst_drop", 32'(bus.pc_wr_drop), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        chk("rst_ready", 32'(bus.req_ready), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int stall;
        logic [1:0] vb;
        logic       rdy0;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        model_reset();

        //          rst v      a0    a1    d0            d1            we3 wa3   wd3           drop idle
        tbl[0]  = '{1, 2'b01, 4'd3, 4'd0, 32'hDEADBEEF, 32'h0,        0, 4'd0, 32'h0,        0, 0};
        tbl[1]  = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        1, 4'd3, 32'hDEADBEEF, 0, 0};
        tbl[2]  = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        0, 4'd3, 32'hDEADBEEF, 0, 1};
        tbl[3]  = '{1, 2'b11, 4'd1, 4'd2, 32'h10000000, 32'h20000000, 0, 4'd0, 32'h0,        0, 0};
        tbl[4]  = '{0, 2'b11, 4'd1, 4'd2, 32'h10000001, 32'h20000001, 1, 4'd1, 32'h10000000, 0, 0};
        tbl[5]  = '{0, 2'b11, 4'd1, 4'd2, 32'h10000002, 32'h20000002, 1, 4'd2, 32'h20000000, 0, 0};
        tbl[6]  = '{0, 2'b11, 4'd1, 4'd2, 32'h10000003, 32'h20000003, 1, 4'd1, 32'h10000001, 0, 0};
        tbl[7]  = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        1, 4'd2, 32'h20000001, 0, 0};
        tbl[8]  = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        1, 4'd1, 32'h10000002, 0, 0};
        tbl[9]  = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        1, 4'd2, 32'h20000003, 0, 0};
        tbl[10] = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        0, 4'd2, 32'h20000003, 0, 1};
        tbl[11] = '{0, 2'b10, 4'd0, 4'hF, 32'h0,        32'h100,      0, 4'd2, 32'h20000003, 1, 1};
        tbl[12] = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        0, 4'd2, 32'h20000003, 0, 1};
        tbl[13] = '{0, 2'b11, 4'hF, 4'hF, 32'h5,        32'h6,        0, 4'd2, 32'h20000003, 1, 1};
        tbl[14] = '{0, 2'b00, 4'd0, 4'd0, 32'h0,        32'h0,        0, 4'd2, 32'h20000003, 0, 1};

        for (int r = 0; r < 15; r++) begin
            if (tbl[r].rst_first) do_reset();
            step(tbl[r].v, tbl[r].a0, tbl[r].a1, tbl[r].d0, tbl[r].d1);
            chk($sformatf("tbl%0d_we3", r), 32'(bus.we3), 32'(tbl[r].we3));
            chk($sformatf("tbl%0d_wa3", r), 32'(bus.wa3), 32'(tbl[r].wa3));
            chk($sformatf("tbl%0d_wd3", r), bus.wd3, tbl[r].wd3);
            chk($sformatf("tbl%0d_drop", r), 32'(bus.pc_wr_drop), 32'(tbl[r].drop));
            chk($sformatf("tbl%0d_idle", r), 32'(bus.idle), 32'(tbl[r].idle));
        end

        // Backpressure: requester 1 streams while requester 0 holds 4 writes to r6.
        do_reset();
        cap.delete();
        sent  = 0;
        stall = 0;
        for (int c = 0; c < 12; c++) begin
            vb   = {1'b1, (sent < 4)};
            rdy0 = bus.req_ready[0];
            if (vb[0] && !rdy0) stall++;
            step(vb, 4'd6, 4'd5, 32'hC0000000 + 32'(sent), 32'h50000000 + 32'(c));
            if (vb[0] && rdy0) sent++;
        end
        for (int c = 0; c < 6; c++) step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        chk("bp_stall_seen", 32'(stall > 0), 32'd1);
        chk("bp_count", 32'(cap.size()), 32'd4);
        for (int i = 0; i < cap.size() && i < 4; i++)
            chk($sformatf("bp_order%0d", i), cap[i], 32'hC0000000 + 32'(i));

        // Reset between clock edges while both FIFOs hold entries.
        do_reset();
        step(2'b11, 4'd8, 4'd9, 32'hAAAA0000, 32'hBBBB0000);
        step(2'b11, 4'd8, 4'd9, 32'hAAAA0001, 32'hBBBB0001);
        chk("midrst_pre_we3", 32'(bus.we3), 32'd1);
        bus.req_valid = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_we3_async", 32'(bus.we3), 32'd0);
        chk("midrst_idle_async", 32'(bus.idle), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
            chk("midrst_no_stale", 32'(bus.we3), 32'd0);
        end
        chk("midrst_idle", 32'(bus.idle), 32'd1);

`ifdef RFW_PENDING_MASK_EN
        do_reset();
        step(2'b01, 4'd4, 4'd0, 32'h44, 32'h0);
        step(2'b10, 4'd0, 4'd7, 32'h0, 32'h77);
        chk("pmask_both", 32'(bus.pending_mask), 32'h0090);
        for (int c = 0; c < 3; c++) step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        chk("pmask_clear", 32'(bus.pending_mask), 32'h0000);
`endif

        // Randomized traffic against the model, r15 included among addresses.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            step(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        for (int c = 0; c < 6; c++) step(2'b00, 4'd0, 4'd0, 32'h0, 32'h0);
        chk("final_idle", 32'(bus.idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
